// File: rtl/fetch_stage_queued.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue in front of the decode register.
// Talks to a variable-latency instruction memory with at most one request in flight.
module fetch_stage_queued #(
    parameter int                 PC_SIZE     = 8,
    parameter int                 INSTR_WIDTH = 32,
    parameter int                 DEPTH       = 4,
    parameter logic [PC_SIZE-1:0] RESET_PC    = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         StallD,
    input  logic                         FlushD,
    input  logic                         PCSrcD,
    input  logic [PC_SIZE-1:0]           PCBranchD,
    output logic                         IMemReq,
    output logic [PC_SIZE-1:0]           IMemAddr,
    input  logic                         IMemValid,
    input  logic [INSTR_WIDTH-1:0]       IMemRD,
    output logic [PC_SIZE-1:0]           PCF,
    output logic [INSTR_WIDTH-1:0]       InstrD,
    output logic [PC_SIZE-1:0]           PCPlus1D,
    output logic                         ValidD,
    output logic [$clog2(DEPTH+1)-1:0]   QueueCount
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [PC_SIZE-1:0]       pcf_q, pcf_d;
    logic [PW-1:0]            head_q, head_d;
    logic [PW-1:0]            tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;
    logic [INSTR_WIDTH-1:0]   dec_instr_q, dec_instr_d;
    logic [PC_SIZE-1:0]       dec_pcp1_q, dec_pcp1_d;
    logic                     dec_valid_q, dec_valid_d;

    logic [INSTR_WIDTH-1:0]   q_instr_mem [DEPTH];
    logic [PC_SIZE-1:0]       q_pc_mem    [DEPTH];

    logic                     push;
    logic                     pop;
    logic                     issue;
    logic [CW:0]              occ_push;
    logic [INSTR_WIDTH-1:0]   head_instr;
    logic [PC_SIZE-1:0]       head_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign push     = IMemValid & (state_q == ST_WAIT) & ~PCSrcD;
    assign pop      = (count_q != '0) & ~StallD & ~FlushD & ~PCSrcD;
    // Space check counts the incoming response but not a concurrent pop.
    assign occ_push = {1'b0, count_q} + {{CW{1'b0}}, push};
    assign issue    = ~reset & ~PCSrcD & ((state_q == ST_RUN) | push)
                    & (occ_push < (CW+1)'(DEPTH));

    assign head_instr = q_instr_mem[head_q];
    assign head_pc    = q_pc_mem[head_q];

    assign IMemReq    = issue;
    assign IMemAddr   = pcf_q;
    assign PCF        = pcf_q;
    assign InstrD     = dec_instr_q;
    assign PCPlus1D   = dec_pcp1_q;
    assign ValidD     = dec_valid_q;
    assign QueueCount = count_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (!PCSrcD && issue) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (PCSrcD) begin
                    state_d = IMemValid ? ST_RUN : ST_DRAIN;
                end else if (push) begin
                    state_d = issue ? ST_WAIT : ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (IMemValid) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pcf_d = pcf_q;
        if (PCSrcD) begin
            pcf_d = PCBranchD;
        end else if (issue) begin
            pcf_d = pcf_q + PC_SIZE'(1);
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (PCSrcD) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_comb begin
        dec_instr_d = dec_instr_q;
        dec_pcp1_d  = dec_pcp1_q;
        dec_valid_d = dec_valid_q;
        if (PCSrcD || FlushD) begin
            dec_instr_d = '0;
            dec_pcp1_d  = '0;
            dec_valid_d = 1'b0;
        end else if (!StallD) begin
            if (pop) begin
                dec_instr_d = head_instr;
                dec_pcp1_d  = head_pc;
                dec_valid_d = 1'b1;
            end else begin
                dec_instr_d = '0;
                dec_pcp1_d  = '0;
                dec_valid_d = 1'b0;
            end
        end
    end

    // Each entry stores the PCF seen at push time, which is the fetched address + 1.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr_mem[tail_q] <= IMemRD;
            q_pc_mem[tail_q]    <= pcf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            pcf_q       <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            dec_instr_q <= '0;
            dec_pcp1_q  <= '0;
            dec_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcf_q       <= pcf_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            dec_instr_q <= dec_instr_d;
            dec_pcp1_q  <= dec_pcp1_d;
            dec_valid_q <= dec_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage_queued.sv
// Bench for fetch_stage_queued: a queue-based reference model plus a memory responder with random latency.
// Directed scenarios pin the model with literal values, then a long randomized run follows.
module tb_fetch_stage_queued;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcD;
    logic [7:0]  PCBranchD;
    logic        IMemReq;
    logic [7:0]  IMemAddr;
    logic        IMemValid;
    logic [31:0] IMemRD;
    logic [7:0]  PCF;
    logic [31:0] InstrD;
    logic [7:0]  PCPlus1D;
    logic        ValidD;
    logic [2:0]  QueueCount;

    fetch_stage_queued #(
        .PC_SIZE    (8),
        .INSTR_WIDTH(32),
        .DEPTH      (DEPTH),
        .RESET_PC   (8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcD    (PCSrcD),
        .PCBranchD (PCBranchD),
        .IMemReq   (IMemReq),
        .IMemAddr  (IMemAddr),
        .IMemValid (IMemValid),
        .IMemRD    (IMemRD),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PCPlus1D  (PCPlus1D),
        .ValidD    (ValidD),
        .QueueCount(QueueCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: fetch pointer, prefetch FIFO, decode slot, request bookkeeping.
    logic [7:0]  m_pc;
    logic [31:0] m_qi[$];
    logic [7:0]  m_qp[$];
    logic [31:0] m_instr;
    logic [7:0]  m_pcp1;
    logic        m_valid;
    bit          m_has;
    bit          m_dead;

    // Memory responder.
    bit          mem_pend;
    int          mem_due;
    logic [31:0] mem_data;
    int          lat_min  = 1;
    int          lat_max  = 1;
    bit          rnd_data = 0;
    bit          spur     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00;
        m_qi.delete();
        m_qp.delete();
        m_instr = '0;
        m_pcp1  = '0;
        m_valid = 1'b0;
        m_has   = 0;
        m_dead  = 0;
        mem_pend = 0;
    endtask

    // One clock cycle: drive inputs, compare every output against the model, advance the model.
    task automatic step(input logic rst, input logic stall, input logic flush,
                        input logic pcsrc, input logic [7:0] br);
        logic        v;
        logic        push;
        logic        pop;
        logic        req;
        logic [31:0] hi;
        logic [7:0]  hp;
        int          sz;
        @(negedge clk);
        v         = mem_pend && (mem_due == cyc);
        reset     = rst;
        StallD    = stall;
        FlushD    = flush;
        PCSrcD    = pcsrc;
        PCBranchD = br;
        IMemValid = v || (spur && !mem_pend && ($urandom_range(0, 3) == 0));
        IMemRD    = v ? mem_data : $urandom;
        #1;
        sz   = m_qi.size();
        push = IMemValid && m_has && !m_dead && !pcsrc;
        pop  = (sz > 0) && !stall && !flush && !pcsrc;
        req  = !rst && !pcsrc && (!m_has || push) && ((sz + int'(push)) < DEPTH);

        chk("IMemReq",    32'(IMemReq),    32'(req));
        chk("IMemAddr",   32'(IMemAddr),   32'(m_pc));
        chk("PCF",        32'(PCF),        32'(m_pc));
        chk("QueueCount", 32'(QueueCount), 32'(sz));
        chk("InstrD",     InstrD,          m_instr);
        chk("PCPlus1D",   32'(PCPlus1D),   32'(m_pcp1));
        chk("ValidD",     32'(ValidD),     32'(m_valid));

        if (rst) begin
            model_reset();
        end else begin
            if (v) mem_pend = 0;
            if (pcsrc) begin
                m_pc = br;
                m_qi.delete();
                m_qp.delete();
                m_instr = '0;
                m_pcp1  = '0;
                m_valid = 1'b0;
                if (m_has && IMemValid) begin
                    m_has  = 0;
                    m_dead = 0;
                end else if (m_has) begin
                    m_dead = 1;
                end
            end else begin
                hi = '0;
                hp = '0;
                if (pop) begin
                    hi = m_qi.pop_front();
                    hp = m_qp.pop_front();
                end
                if (flush) begin
                    m_instr = '0;
                    m_pcp1  = '0;
                    m_valid = 1'b0;
                end else if (!stall) begin
                    m_instr = hi;
                    m_pcp1  = hp;
                    m_valid = pop;
                end
                if (m_has && IMemValid) begin
                    if (!m_dead) begin
                        m_qi.push_back(IMemRD);
                        m_qp.push_back(m_pc);
                    end
                    m_has  = 0;
                    m_dead = 0;
                end
                if (req) begin
                    m_has    = 1;
                    m_dead   = 0;
                    mem_pend = 1;
                    mem_due  = cyc + $urandom_range(lat_min, lat_max);
                    mem_data = 32'(m_pc) + 32'd100 + (rnd_data ? ($urandom << 8) : 32'd0);
                    m_pc     = m_pc + 8'd1;
                end
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Steps until ValidD is seen, bounded; an expired bound counts as a failure.
    task automatic wait_valid(input string name);
        bit found;
        found = 0;
        for (int n = 0; n < 30 && !found; n++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            if (ValidD === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s_timeout actual=no_valid expected=valid_within_30", name);
        end
    endtask

    logic [7:0]  a_log [8];
    logic        r_log [8];
    logic [31:0] i_log [8];
    logic [7:0]  p_log [8];
    logic        v_log [8];

    task automatic log_run(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            a_log[i] = IMemAddr;
            r_log[i] = IMemReq;
            i_log[i] = InstrD;
            p_log[i] = PCPlus1D;
            v_log[i] = ValidD;
        end
    endtask

    initial begin
        reset = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcD = 1'b0;
        PCBranchD = 8'h00; IMemValid = 1'b0; IMemRD = '0;
        model_reset();

        // 1-cycle memory streaming from reset
        do_reset();
        log_run(6);
        for (int i = 0; i < 3; i++) begin
            chk("t1_addr", 32'(a_log[i]), 32'(i));
            chk("t1_req",  32'(r_log[i]), 32'd1);
        end
        for (int i = 3; i < 6; i++) begin
            chk("t1_instr", i_log[i], 32'(100 + i - 3));
            chk("t1_pcp1",  32'(p_log[i]), 32'(i - 2));
            chk("t1_valid", 32'(v_log[i]), 32'd1);
        end

        // Stall from reset fills the queue, then drains in order
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("t2_count", 32'(QueueCount), 32'd4);
        chk("t2_req",   32'(IMemReq),    32'd0);
        chk("t2_pcf",   32'(PCF),        32'd4);
        chk("t2_valid", 32'(ValidD),     32'd0);
        log_run(6);
        for (int i = 1; i < 6; i++) chk("t2_instr", i_log[i], 32'(99 + i));

        // Redirect during steady flow with two queued entries
        do_reset();
        run(6);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h40);
        chk("t3_count_before", 32'(QueueCount), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t3_count", 32'(QueueCount), 32'd0);
        chk("t3_valid", 32'(ValidD),     32'd0);
        chk("t3_pcf",   32'(PCF),        32'h40);
        chk("t3_addr",  32'(IMemAddr),   32'h40);
        wait_valid("t3");
        chk("t3_instr", InstrD,          32'hA4);
        chk("t3_pcp1",  32'(PCPlus1D),   32'h41);

        // 3-cycle memory: redirect while 0x05 is in flight
        lat_min = 3; lat_max = 3;
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t4_req05",  32'(IMemReq),  32'd1);
        chk("t4_addr05", 32'(IMemAddr), 32'h05);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h20);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t4_drain_req", 32'(IMemReq), 32'd0);
        chk("t4_pcf",       32'(PCF),     32'h20);
        wait_valid("t4");
        chk("t4_instr", InstrD,        32'h84);
        chk("t4_pcp1",  32'(PCPlus1D), 32'h21);

        // PC wrap FE -> FF -> 00
        lat_min = 1; lat_max = 1;
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'hFE);
        log_run(6);
        chk("t5_addr0", 32'(a_log[0]), 32'hFE);
        chk("t5_addr1", 32'(a_log[1]), 32'hFF);
        chk("t5_addr2", 32'(a_log[2]), 32'h00);
        chk("t5_pcp1a", 32'(p_log[3]), 32'hFF);
        chk("t5_pcp1b", 32'(p_log[4]), 32'h00);
        chk("t5_pcp1c", 32'(p_log[5]), 32'h01);

        // StallD and FlushD together with three queued entries
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t6_count", 32'(QueueCount), 32'd3);
        chk("t6_valid", 32'(ValidD),     32'd0);
        chk("t6_instr", InstrD,          32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t6_head",  InstrD,          32'd101);
        chk("t6_hvalid", 32'(ValidD),    32'd1);

        // Randomized traffic with variable latency and stray valids
        rnd_data = 1; spur = 1; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0),
                 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
